// File: rtl/fifo_wr_scheduler_if.sv
// Handshake and FIFO write-port bundle between the write scheduler, its two
// requesters (ALU, register file) and the async FIFO write side.
interface fifo_wr_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    I_ALU_VLD;
    logic [2*DATA_WIDTH-1:0] I_ALU_DATA;
    logic                    I_RF_VLD;
    logic [DATA_WIDTH-1:0]   I_RF_DATA;
    logic                    I_FULL;
    logic                    O_W_INC;
    logic [DATA_WIDTH-1:0]   O_W_DATA;
    logic                    O_ALU_ACK;
    logic                    O_RF_ACK;
    logic                    O_BUSY;
    logic [1:0]              dbg_state;

    // Requesters and FIFO side.
    modport master (
        output I_ALU_VLD, I_ALU_DATA, I_RF_VLD, I_RF_DATA, I_FULL,
        input  O_W_INC, O_W_DATA, O_ALU_ACK, O_RF_ACK, O_BUSY, dbg_state
    );

    // Scheduler side.
    modport slave (
        input  I_ALU_VLD, I_ALU_DATA, I_RF_VLD, I_RF_DATA, I_FULL,
        output O_W_INC, O_W_DATA, O_ALU_ACK, O_RF_ACK, O_BUSY, dbg_state
    );
endinterface

// File: rtl/fifo_wr_scheduler.sv
// Write-domain scheduler: round-robin arbitration between ALU and register file,
// serialising each request into FIFO words while honouring the FIFO full flag.
module fifo_wr_scheduler #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                I_CLK,
    input  logic                I_RST,
    fifo_wr_scheduler_if.slave  bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_RF = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    // Handshake: a requester holds VLD (and data) until it samples its ACK high,
    // then drops VLD on that same edge. ACK is a one-cycle pulse in the cycle
    // after the grant; the FIFO accepts a word on every edge where O_W_INC=1.

    state_t         state;
    logic           prio_alu;   // 1: ALU wins the next tie, 0: RF wins
    logic [2*W-1:0] hold;       // low W bits always carry the word being written
    logic           alu_ack;
    logic           rf_ack;

    logic grant_alu;
    logic grant_rf;
    logic both_vld;
    logic w_inc;

    always_comb begin
        both_vld  = bus.I_ALU_VLD & bus.I_RF_VLD;
        grant_alu = bus.I_ALU_VLD & (~bus.I_RF_VLD | prio_alu);
        grant_rf  = bus.I_RF_VLD & ~grant_alu;
    end

    // Combinational from registered state so a rising full flag blocks the write at once.
    assign w_inc = (state != IDLE) & ~bus.I_FULL;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state    <= IDLE;
            prio_alu <= 1'b1;
            hold     <= '0;
            alu_ack  <= 1'b0;
            rf_ack   <= 1'b0;
        end else begin
            alu_ack <= 1'b0;
            rf_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (both_vld) begin
                        prio_alu <= ~prio_alu;
                    end
                    if (grant_alu) begin
                        hold    <= bus.I_ALU_DATA;
                        alu_ack <= 1'b1;
                        state   <= WR_LO;
                    end else if (grant_rf) begin
                        hold    <= {{W{1'b0}}, bus.I_RF_DATA};
                        rf_ack  <= 1'b1;
                        state   <= WR_RF;
                    end
                end
                WR_RF: begin
                    if (w_inc) state <= IDLE;
                end
                WR_LO: begin
                    // Shift the high half down so it becomes the next write word.
                    if (w_inc) begin
                        hold  <= {{W{1'b0}}, hold[2*W-1:W]};
                        state <= WR_HI;
                    end
                end
                WR_HI: begin
                    if (w_inc) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.O_W_INC   = w_inc;
    assign bus.O_W_DATA  = hold[W-1:0];
    assign bus.O_ALU_ACK = alu_ack;
    assign bus.O_RF_ACK  = rf_ack;
    assign bus.O_BUSY    = (state != IDLE);
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_fifo_wr_scheduler.sv
// Directed bench for fifo_wr_scheduler: reset, single requests, round-robin,
// full back-pressure and mid-transfer reset, with a scoreboard on FIFO writes.
module tb_fifo_wr_scheduler;
    localparam int W = 8;

    logic clk;
    logic rst;

    fifo_wr_scheduler_if #(.DATA_WIDTH(W)) bus ();

    fifo_wr_scheduler #(.DATA_WIDTH(W)) dut (
        .I_CLK (clk),
        .I_RST (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    logic [W-1:0] exp_q[$];
    logic [W:0]   exp_w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: every accepted FIFO word must be the next expected one.
    always @(negedge clk) begin
        if (bus.O_W_INC === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() > 0) exp_w = {1'b0, exp_q.pop_front()};
            else                  exp_w = 9'h100;
            chk("fifo_wr", {23'd0, 1'b0, bus.O_W_DATA}, {23'd0, exp_w});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic alu_req(input logic [2*W-1:0] data);
        logic seen;
        seen = 1'b0;
        bus.I_ALU_VLD  = 1'b1;
        bus.I_ALU_DATA = data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.O_ALU_ACK) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.I_ALU_VLD = 1'b0;
        chk("alu_ack_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic rf_req(input logic [W-1:0] data);
        logic seen;
        seen = 1'b0;
        bus.I_RF_VLD  = 1'b1;
        bus.I_RF_DATA = data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.O_RF_ACK) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.I_RF_VLD = 1'b0;
        chk("rf_ack_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.O_BUSY && exp_q.size() == 0) break;
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        bus.I_ALU_VLD  = 1'b0;
        bus.I_ALU_DATA = '0;
        bus.I_RF_VLD   = 1'b0;
        bus.I_RF_DATA  = '0;
        bus.I_FULL     = 1'b0;

        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_w_inc", {31'd0, bus.O_W_INC}, 32'd0);
        chk("rst_w_data", {24'd0, bus.O_W_DATA}, 32'h00);
        chk("rst_busy", {31'd0, bus.O_BUSY}, 32'd0);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_w_inc", {31'd0, bus.O_W_INC}, 32'd0);
        chk("idle_w_data", {24'd0, bus.O_W_DATA}, 32'h00);
        chk("idle_busy", {31'd0, bus.O_BUSY}, 32'd0);
        chk("idle_acks", {30'd0, bus.O_ALU_ACK, bus.O_RF_ACK}, 32'd0);

        // 2. single RF request 0xA5
        @(posedge clk); #1;
        bus.I_RF_VLD  = 1'b1;
        bus.I_RF_DATA = 8'hA5;
        exp_q.push_back(8'hA5);
        @(posedge clk);                     // grant edge
        @(negedge clk);
        chk("rf_ack_pulse", {31'd0, bus.O_RF_ACK}, 32'd1);
        chk("rf_alu_ack", {31'd0, bus.O_ALU_ACK}, 32'd0);
        chk("rf_w_inc", {31'd0, bus.O_W_INC}, 32'd1);
        chk("rf_w_data", {24'd0, bus.O_W_DATA}, 32'hA5);
        chk("rf_busy", {31'd0, bus.O_BUSY}, 32'd1);
        @(posedge clk); #1;                 // write edge, ACK sampled
        bus.I_RF_VLD = 1'b0;
        @(negedge clk);
        chk("rf_ack_drop", {31'd0, bus.O_RF_ACK}, 32'd0);
        chk("rf_w_inc_drop", {31'd0, bus.O_W_INC}, 32'd0);
        chk("rf_busy_drop", {31'd0, bus.O_BUSY}, 32'd0);
        wait_idle("rf_drain");

        // 3. single ALU request 0x1234
        @(posedge clk); #1;
        bus.I_ALU_VLD  = 1'b1;
        bus.I_ALU_DATA = 16'h1234;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        @(posedge clk);
        @(negedge clk);
        chk("alu_ack_pulse", {31'd0, bus.O_ALU_ACK}, 32'd1);
        chk("alu_lo_inc", {31'd0, bus.O_W_INC}, 32'd1);
        chk("alu_lo_data", {24'd0, bus.O_W_DATA}, 32'h34);
        @(posedge clk); #1;
        bus.I_ALU_VLD = 1'b0;
        @(negedge clk);
        chk("alu_ack_drop", {31'd0, bus.O_ALU_ACK}, 32'd0);
        chk("alu_hi_inc", {31'd0, bus.O_W_INC}, 32'd1);
        chk("alu_hi_data", {24'd0, bus.O_W_DATA}, 32'h12);
        @(posedge clk);
        @(negedge clk);
        chk("alu_done_inc", {31'd0, bus.O_W_INC}, 32'd0);
        chk("alu_done_busy", {31'd0, bus.O_BUSY}, 32'd0);
        wait_idle("alu_drain");

        // 4. simultaneous requests, round-robin
        do_reset();
        @(posedge clk); #1;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'h5A);
        fork
            alu_req(16'hBEEF);
            rf_req(8'h5A);
        join
        wait_idle("rr1_drain");
        @(posedge clk); #1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        fork
            alu_req(16'hBEEF);
            rf_req(8'h3C);
        join
        wait_idle("rr2_drain");

        // 5. FIFO full for 3 cycles during the high word
        wr_cnt = 0;
        @(posedge clk); #1;
        bus.I_ALU_VLD  = 1'b1;
        bus.I_ALU_DATA = 16'hCAFE;
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hCA);
        @(posedge clk);                     // grant
        @(posedge clk); #1;                 // low word written
        bus.I_ALU_VLD = 1'b0;
        bus.I_FULL    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_w_inc", {31'd0, bus.O_W_INC}, 32'd0);
            chk("full_w_data", {24'd0, bus.O_W_DATA}, 32'hCA);
            chk("full_busy", {31'd0, bus.O_BUSY}, 32'd1);
        end
        @(posedge clk); #1;
        bus.I_FULL = 1'b0;
        @(negedge clk);
        chk("resume_w_inc", {31'd0, bus.O_W_INC}, 32'd1);
        chk("resume_w_data", {24'd0, bus.O_W_DATA}, 32'hCA);
        wait_idle("full_drain");
        repeat (2) @(negedge clk);
        chk("cafe_writes", wr_cnt, 32'd2);

        // 6. reset during the high word of 0x00FF
        @(posedge clk); #1;
        bus.I_ALU_VLD  = 1'b1;
        bus.I_ALU_DATA = 16'h00FF;
        exp_q.push_back(8'hFF);
        @(posedge clk);
        @(posedge clk); #1;                 // low word written, now WR_HI
        bus.I_ALU_VLD = 1'b0;
        chk("pre_rst_state", {30'd0, bus.dbg_state}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_inc", {31'd0, bus.O_W_INC}, 32'd0);
        chk("rst_async_state", {30'd0, bus.dbg_state}, 32'd0);
        chk("rst_async_busy", {31'd0, bus.O_BUSY}, 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(8'h77);
        rf_req(8'h77);
        wait_idle("post_rst_drain");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
